// File: rtl/round_unit.sv
// round_unit: one cipher-style round (key mix, nibble S-box, linear diffusion)
// with a single output register stage. Latency 1 cycle, throughput 1 block/cycle.
//
// Flow control: IN_VALID qualifies D_IN/K_IN for the current cycle only. There
// is no ready/back-pressure; every IN_VALID cycle is accepted, and OUT_VALID
// pulses for exactly one cycle alongside the D_OUT update it belongs to. The
// consumer must take every OUT_VALID pulse.
module round_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic [31:0] D_IN,
  input  logic [7:0]  K_IN,
  output logic [31:0] D_OUT,
  output logic        OUT_VALID
);

  // 4-bit substitution box shared by all eight nibble lanes.
  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] r;
    unique case (n)
      4'h0: r = 4'hC;
      4'h1: r = 4'h5;
      4'h2: r = 4'h6;
      4'h3: r = 4'hB;
      4'h4: r = 4'h9;
      4'h5: r = 4'h0;
      4'h6: r = 4'hA;
      4'h7: r = 4'hD;
      4'h8: r = 4'h3;
      4'h9: r = 4'hE;
      4'hA: r = 4'hF;
      4'hB: r = 4'h8;
      4'hC: r = 4'h4;
      4'hD: r = 4'h7;
      4'hE: r = 4'h1;
      default: r = 4'h2;
    endcase
    return r;
  endfunction

  logic [31:0] key32;
  logic [31:0] mix_x;
  logic [31:0] sub_s;
  logic [31:0] lin_y;

  logic [31:0] dout_q,  dout_d;
  logic        valid_q, valid_d;

  // Combinational round datapath: replicate key, XOR-mix, substitute, diffuse.
  always_comb begin
    key32 = {K_IN, K_IN, K_IN, K_IN};
    mix_x = D_IN ^ key32;
    sub_s = '0;
    for (int i = 0; i < 8; i++) begin
      sub_s[4*i +: 4] = sbox(mix_x[4*i +: 4]);
    end
    // rotl32 by 8 and by 19; both are pure wiring.
    lin_y = sub_s ^ {sub_s[23:0], sub_s[31:24]} ^ {sub_s[12:0], sub_s[31:13]};
  end

  // Next-state for the output stage: capture on IN_VALID, otherwise hold data
  // and drop the valid pulse. Reset wins over any block offered the same cycle.
  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (RST) begin
      dout_d  = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (IN_VALID) begin
      dout_d  = lin_y;
      valid_d = 1'b1;
    end
  end

  // Output register stage.
  always_ff @(posedge CLK) begin
    dout_q  <= dout_d;
    valid_q <= valid_d;
  end

  assign D_OUT     = dout_q;
  assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_round_unit.sv
// Bench for round_unit: a directed table of per-cycle vectors covering reset,
// the known-answer blocks, hold behaviour and mid-stream reset, followed by a
// random stream checked against an independent bit-level reference model.
module tb_round_unit;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic [31:0] D_IN;
  logic [7:0]  K_IN;
  logic [31:0] D_OUT;
  logic        OUT_VALID;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];

  round_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .D_IN      (D_IN),
    .K_IN      (K_IN),
    .D_OUT     (D_OUT),
    .OUT_VALID (OUT_VALID)
  );

  // Clock / reset block: 10 ns period, inputs start idle with reset asserted.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b0;
    D_IN     = '0;
    K_IN     = '0;
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] d;
    logic [7:0]  k;
    logic [31:0] exp_dout;
    logic        exp_vld;
    string       name;
  } vec_t;

  // Reference round built bit by bit: S-box from a packed table, rotations by
  // index arithmetic.
  function automatic logic [31:0] ref_round(input logic [31:0] d, input logic [7:0] k);
    logic [63:0] tbl;
    logic [31:0] x;
    logic [31:0] s;
    logic [31:0] y;
    int          n;
    tbl = 64'hC56B_90AD_3EF8_4712;
    x   = d ^ {4{k}};
    s   = '0;
    for (int j = 0; j < 8; j++) begin
      n = int'(x[4*j +: 4]);
      s[4*j +: 4] = tbl[60 - 4*n +: 4];
    end
    y = '0;
    for (int b = 0; b < 32; b++) begin
      y[b] = s[b] ^ s[(b + 24) % 32] ^ s[(b + 13) % 32];
    end
    return y;
  endfunction

  // Driver: present one cycle of inputs on the falling edge, then sample the
  // registered outputs 1 ns after the next rising edge.
  task automatic drive_cycle(input logic rst, input logic vld,
                             input logic [31:0] d, input logic [7:0] k);
    @(negedge CLK);
    RST      = rst;
    IN_VALID = vld;
    D_IN     = d;
    K_IN     = k;
    @(posedge CLK);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  vec_t vecs[14];

  initial begin : main
    logic [31:0] last_dout;
    logic        prev_vld;
    logic        vld;
    logic [31:0] d;
    logic [7:0]  k;
    logic [31:0] exp_v;

    tests_run    = 0;
    tests_failed = 0;

    // Known-answer check of the reference model itself against hand values.
    check32("ref_model_kat0", ref_round(32'h0000_0000, 8'h00), 32'h6666_6666);
    check32("ref_model_kat1", ref_round(32'h0000_000F, 8'h00), 32'h6616_6868);

    // Each row is one rising edge: inputs applied, outputs expected after it.
    vecs[0]  = '{1'b1, 1'b1, 32'h1234_5678, 8'hAA, 32'h0000_0000, 1'b0, "reset_discards_block"};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b0, "reset_cycle2"};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b0, "post_reset_idle"};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 8'h00, 32'h6666_6666, 1'b1, "zero_zero"};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 8'hFF, 32'h1111_1111, 1'b1, "zero_keyff"};
    vecs[5]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 8'hFF, 32'h6666_6666, 1'b1, "ones_keyff_b2b"};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_000F, 8'h00, 32'h6616_6868, 1'b1, "low_nibble_f"};
    vecs[7]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 8'h55, 32'h6616_6868, 1'b0, "hold_1"};
    vecs[8]  = '{1'b0, 1'b0, 32'hCAFE_F00D, 8'h3C, 32'h6616_6868, 1'b0, "hold_2"};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 8'h00, 32'h6616_6868, 1'b0, "hold_3"};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 8'h00, 32'h6666_6666, 1'b1, "pre_midreset"};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_000F, 8'h00, 32'h0000_0000, 1'b0, "midstream_reset"};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0000, 8'hFF, 32'h1111_1111, 1'b1, "resume_after_reset"};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 8'h00, 32'h1111_1111, 1'b0, "resume_hold"};

    for (int i = 0; i < 14; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].vld, vecs[i].d, vecs[i].k);
      check32({vecs[i].name, "_dout"}, D_OUT, vecs[i].exp_dout);
      check1({vecs[i].name, "_valid"}, OUT_VALID, vecs[i].exp_vld);
    end

    // Random stream with occasional gaps; scoreboard holds expected results.
    last_dout = 32'h1111_1111;
    prev_vld  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      vld = ($urandom_range(0, 3) != 0);
      d   = $urandom();
      k   = 8'($urandom_range(0, 255));
      if (vld) exp_q.push_back(ref_round(d, k));
      drive_cycle(1'b0, vld, d, k);
      check1("rand_valid", OUT_VALID, vld);
      if (vld) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL rand_queue: got empty queue expected an entry");
        end else begin
          exp_v = exp_q.pop_front();
          check32("rand_dout", D_OUT, exp_v);
          last_dout = exp_v;
        end
      end else begin
        check32("rand_hold", D_OUT, last_dout);
      end
      prev_vld = vld;
    end

    drive_cycle(1'b0, 1'b0, 32'h0, 8'h0);
    check1("tail_valid_low", OUT_VALID, 1'b0);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends even if the main sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
